// File: rtl/mc10136_pkg.sv
// Shared types for mc10136 counter-chain users: chain mode encoding and sequencer states.
package mc10136_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        INC  = 2'b01,
        DEC  = 2'b10,
        HOLD = 2'b11
    } tCounterMode;

    // State names carry a prefix so they do not collide with the chain-mode LOAD.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_FIN  = 2'b11
    } tSeqState;

    function automatic tCounterMode mode_for_dir(input logic up);
        tCounterMode m;
        if (up) begin
            m = INC;
        end else begin
            m = DEC;
        end
        return m;
    endfunction

endpackage

// File: rtl/mc10136_seq_if.sv
// Request/response and counter-chain control bundle of the mc10136 sequencer.
interface mc10136_seq_if #(
    parameter int SW = 12
);
    logic          start;
    logic          dir;
    logic          stall;
    logic          abort;
    logic          tc;
    logic          sel2;
    logic          sel1;
    logic          nCryIn;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] steps;

    modport master (
        output start, dir, stall, abort, tc,
        input  sel2, sel1, nCryIn, busy, done, err, steps
    );

    modport slave (
        input  start, dir, stall, abort, tc,
        output sel2, sel1, nCryIn, busy, done, err, steps
    );
endinterface

// File: rtl/mc10136_seq_watchdog.sv
// Saturating RUN-cycle counter; expired flags the cycle whose increment reaches MAXCYC.
module seq_watchdog #(
    parameter int MAXCYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(MAXCYC + 1);
    localparam logic [CW-1:0] LIM     = CW'(MAXCYC);
    localparam logic [CW-1:0] LIM_M1  = CW'(MAXCYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [CW-1:0] cnt_r;

    // Cycle counter: cleared on sequence start, stops at MAXCYC instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (en && (cnt_r != LIM)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign expired = (cnt_r >= LIM_M1);
endmodule

// File: rtl/mc10136_seq.sv
// Sequencer for a cascaded mc10136 chain: load, step until terminal count, report done/err/steps.
module mc10136_seq
    import mc10136_pkg::*;
#(
    parameter int MAXCYC = 1024,
    parameter int SW     = 12
) (
    input logic          clk,
    input logic          reset,
    mc10136_seq_if.slave bus
);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [SW-1:0] STEP_ZERO = SW'(0);
    localparam logic [SW-1:0] STEP_MAX  = {SW{1'b1}};

    tSeqState    state_r;
    tSeqState    state_nxt_s;
    logic        dir_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [SW-1:0] steps_r;

    tCounterMode mode_s;
    logic        ncry_s;
    logic        step_s;
    logic        start_acc_s;
    logic        wd_en_s;
    logic        wd_exp_s;
    logic        err_set_s;

    seq_watchdog #(.MAXCYC(MAXCYC)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_acc_s),
        .en      (wd_en_s),
        .expired (wd_exp_s)
    );

    // Chain mode and carry-in decode; terminal count gates carry so the chain stops on it.
    always_comb begin
        mode_s = HOLD;
        ncry_s = 1'b1;
        case (state_r)
            ST_LOAD: mode_s = LOAD;
            ST_RUN: begin
                mode_s = mode_for_dir(dir_r);
                ncry_s = ~(~bus.stall & ~bus.tc);
            end
            default: begin
                mode_s = HOLD;
                ncry_s = 1'b1;
            end
        endcase
        step_s = (state_r == ST_RUN) & ~ncry_s;
    end

    // Next-state logic; abort outranks tc and watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        wd_en_s     = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt_s = ST_LOAD;
                    start_acc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_en_s = 1'b1;
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.tc) begin
                    state_nxt_s = ST_FIN;
                end else if (wd_exp_s) begin
                    state_nxt_s = ST_FIN;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and direction captured with an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            dir_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_acc_s) begin
                dir_r <= bus.dir;
            end
        end
    end

    // Status outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            steps_r <= STEP_ZERO;
        end else begin
            busy_r <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_RUN);
            done_r <= (state_nxt_s == ST_FIN);
            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (start_acc_s) begin
                steps_r <= STEP_ZERO;
            end else if (step_s && (steps_r != STEP_MAX)) begin
                steps_r <= steps_r + STEP_ONE;
            end
        end
    end

    assign bus.sel2   = mode_s[1];
    assign bus.sel1   = mode_s[0];
    assign bus.nCryIn = ncry_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.steps  = steps_r;
endmodule

// File: tb/tb_mc10136_seq.sv
// Directed bench: sequencer driving a behavioural 12-bit chain of three mc10136 slices.
module tb_mc10136_seq;
    logic clk;
    logic reset;
    logic [11:0] chain_q;
    logic [11:0] chain_d;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    int          res_done_cyc;
    int          res_low;
    int          res_abort_cyc;
    logic [11:0] res_steps;
    logic        res_err;
    logic [1:0]  res_mode_c1;
    logic        res_busy_c1;
    logic        res_busy_after;

    mc10136_seq_if #(.SW(12)) bus ();

    mc10136_seq #(.MAXCYC(8), .SW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: 00 load, 01 up, 10 down (both gated by carry-in), 11 hold.
    always @(posedge clk) begin
        case ({bus.sel2, bus.sel1})
            2'b00: chain_q <= chain_d;
            2'b01: if (!bus.nCryIn) chain_q <= chain_q + 12'd1;
            2'b10: if (!bus.nCryIn) chain_q <= chain_q - 12'd1;
            default: chain_q <= chain_q;
        endcase
    end

    assign bus.tc = (({bus.sel2, bus.sel1} == 2'b01) && (chain_q == 12'hFFF)) ||
                    (({bus.sel2, bus.sel1} == 2'b10) && (chain_q == 12'h000));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one sequence (start sampled at edge 0) and observe cycles 1..max_cyc at negedge.
    task automatic run_seq(input logic [11:0] d, input logic up, input int sa, input int sb,
                           input int ab, input int max_cyc);
        int run_idx;
        run_idx        = 0;
        res_done_cyc   = -1;
        res_low        = 0;
        res_abort_cyc  = -10;
        res_steps      = 12'hx;
        res_err        = 1'bx;
        res_busy_after = 1'bx;
        @(negedge clk);
        chain_d   = d;
        bus.dir   = up;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.start = 1'b0;
            bus.stall = 1'b0;
            bus.abort = 1'b0;
            if (bus.busy && ({bus.sel2, bus.sel1} != 2'b00)) begin
                run_idx++;
                bus.stall = (run_idx == sa) || (run_idx == sb);
                if (run_idx == ab) begin
                    bus.abort     = 1'b1;
                    bus.start     = 1'b1;
                    res_abort_cyc = cyc;
                end
            end
            if (cyc == 1) begin
                res_mode_c1 = {bus.sel2, bus.sel1};
                res_busy_c1 = bus.busy;
            end
            if (cyc == res_abort_cyc + 1) res_busy_after = bus.busy;
            #1;
            if (!bus.nCryIn) res_low++;
            if (bus.done && (res_done_cyc < 0)) begin
                res_done_cyc = cyc;
                res_steps    = bus.steps;
                res_err      = bus.err;
            end
            if (res_done_cyc >= 0) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        if (ab > 0) res_steps = bus.steps;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        chain_d   = 12'd0;
        repeat (2) @(negedge clk);
        check("rst_sel",   {30'd0, bus.sel2, bus.sel1}, 32'd3);
        check("rst_ncry",  {31'd0, bus.nCryIn}, 32'd1);
        check("rst_busy",  {31'd0, bus.busy},   32'd0);
        check("rst_done",  {31'd0, bus.done},   32'd0);
        check("rst_err",   {31'd0, bus.err},    32'd0);
        check("rst_steps", {20'd0, bus.steps},  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Load 5, count down
        run_seq(12'd5, 1'b0, 0, 0, 0, 40);
        check("dec5_mode_c1", {30'd0, res_mode_c1}, 32'd0);
        check("dec5_busy_c1", {31'd0, res_busy_c1}, 32'd1);
        check("dec5_low",   res_low,        32'd5);
        check("dec5_done",  res_done_cyc,   32'd8);
        check("dec5_steps", {20'd0, res_steps}, 32'd5);
        check("dec5_err",   {31'd0, res_err},   32'd0);
        check("dec5_chain", {20'd0, chain_q},   32'd0);

        // Load 0 down, then all-ones up: immediate terminal count
        run_seq(12'd0, 1'b0, 0, 0, 0, 40);
        check("dec0_low",   res_low,        32'd0);
        check("dec0_done",  res_done_cyc,   32'd3);
        check("dec0_steps", {20'd0, res_steps}, 32'd0);
        run_seq(12'hFFF, 1'b1, 0, 0, 0, 40);
        check("incfff_low",   res_low,        32'd0);
        check("incfff_done",  res_done_cyc,   32'd3);
        check("incfff_steps", {20'd0, res_steps}, 32'd0);
        check("incfff_chain", {20'd0, chain_q},   32'hFFF);

        // Load 4 down, stalls in RUN cycles 2 and 3
        run_seq(12'd4, 1'b0, 2, 3, 0, 40);
        check("stall_low",   res_low,        32'd4);
        check("stall_done",  res_done_cyc,   32'd9);
        check("stall_steps", {20'd0, res_steps}, 32'd4);
        check("stall_chain", {20'd0, chain_q},   32'd0);

        // Load 7 down: tc lands on the watchdog's last cycle and wins
        run_seq(12'd7, 1'b0, 0, 0, 0, 40);
        check("wdedge_done",  res_done_cyc,   32'd10);
        check("wdedge_steps", {20'd0, res_steps}, 32'd7);
        check("wdedge_err",   {31'd0, res_err},   32'd0);

        // Load 100 down with MAXCYC = 8: watchdog expiry
        run_seq(12'd100, 1'b0, 0, 0, 0, 40);
        check("wd_done",  res_done_cyc,   32'd10);
        check("wd_err",   {31'd0, res_err},   32'd1);
        check("wd_steps", {20'd0, res_steps}, 32'd8);
        check("wd_low",   res_low,        32'd8);
        check("wd_chain", {20'd0, chain_q},   32'd92);
        repeat (3) @(negedge clk);
        check("wd_err_held", {31'd0, bus.err}, 32'd1);

        // Load 10, abort (with a concurrent start) in RUN cycle 3
        run_seq(12'd10, 1'b0, 0, 0, 3, 12);
        check("abort_cyc",   res_abort_cyc,  32'd4);
        check("abort_nodone", {31'd0, res_done_cyc >= 0}, 32'd0);
        check("abort_idle",  {31'd0, res_busy_after}, 32'd0);
        check("abort_busy_end", {31'd0, bus.busy}, 32'd0);
        check("abort_steps", {20'd0, res_steps}, 32'd3);
        check("abort_chain", {20'd0, chain_q},   32'd7);
        check("abort_err",   {31'd0, bus.err},   32'd0);

        // Reset asserted mid-RUN
        @(negedge clk);
        chain_d   = 12'd50;
        bus.dir   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_sel",   {30'd0, bus.sel2, bus.sel1}, 32'd3);
        check("arst_ncry",  {31'd0, bus.nCryIn}, 32'd1);
        check("arst_busy",  {31'd0, bus.busy},   32'd0);
        check("arst_steps", {20'd0, bus.steps},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_chain_hold", {20'd0, chain_q}, 32'd49);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/mc10136_seq.md
# mc10136_seq

Sequencer for a cascaded chain of mc10136 universal counter slices. It drives the chain's mode selects (sel2, sel1) and carry-in enable (nCryIn). It loads a count, steps the chain up or down until the chain reports terminal count, then returns a done pulse to the requesting datapath control. It sits directly upstream of the counter chain and is used for loop and shift-count style operations, with stall, abort and watchdog handling.

## Interface
Parameters:
- MAXCYC, 1024: watchdog limit, in RUN-state cycles including stalled cycles.
- SW, 12: width of the step-count output.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- dir  in  1  0 = count down (DEC), 1 = count up (INC); captured with start.
- stall  in  1  hold the chain for this cycle while in RUN.
- abort  in  1  terminate the sequence with no done pulse.
- tc  in  1  terminal count from the chain: AND of inverted nCryOut of all slices.
- sel2, sel1  out  1 each  chain mode. {sel2,sel1}: 00 LOAD, 01 INC, 10 DEC, 11 HOLD.
- nCryIn  out  1  active-low carry-in enable to the least-significant slice.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  watchdog expiry flag; valid with done, held until the next start.
- steps  out  SW  number of chain steps taken in the current or last sequence.

## Operation
- States: IDLE, LOAD, RUN, FIN.
- IDLE:
  - Chain mode is HOLD and nCryIn = 1.
  - start & !abort captures dir, clears steps, err and the watchdog, and goes to LOAD.
- LOAD:
  - Chain mode is LOAD for exactly one cycle, so the chain takes its d inputs at that edge.
  - nCryIn = 1.
  - Next state is RUN.
- RUN:
  - Chain mode is INC if the captured dir = 1, DEC otherwise.
  - nCryIn = !( !stall & !tc ).
  - When enabled (nCryIn = 0), the chain steps once per cycle and steps increments, saturating at all-ones.
  - tc = 1 goes to FIN without stepping. The chain stops exactly on terminal count.
  - The watchdog increments every RUN cycle. Reaching MAXCYC with tc = 0 sets err and goes to FIN.
- FIN:
  - Chain mode is HOLD and done = 1.
  - Next state is IDLE.
- abort in LOAD or RUN goes to IDLE next cycle. There is no done pulse. err and steps keep their values.
- abort has priority over start and over tc in the same cycle.
- start is ignored outside IDLE.
- sel2, sel1 and nCryIn are combinational decodes of the registered state, the captured dir, stall and tc.
- busy, done, err and steps are registered.
- The watchdog counter is $clog2(MAXCYC+1) bits wide and never wraps.

## Timing
- Reset, asynchronous: state IDLE; busy, done, err = 0; steps = 0; chain outputs at HOLD (sel2 = sel1 = 1, nCryIn = 1).
- Reset asserted mid-sequence forces these values immediately.
- Start to chain load: start sampled at edge 0, LOAD during cycle 1, chain loads at edge 2, RUN from cycle 2.
- Loaded count N in DEC with no stalls: N stepping cycles, then one RUN cycle with tc = 1, then FIN.
  - done is high in cycle N+3 after start, with steps = N.
- Loaded count 0 in DEC (or all-ones in INC): tc = 1 in the first RUN cycle, steps = 0, done in cycle 3.
- Each stalled cycle delays done by exactly one cycle.
- Back-to-back: start may be asserted in the FIN cycle's successor (IDLE). The minimum period is therefore 4 cycles plus steps.

## Structure
- The shared package mc10136_pkg holds:
  - tCounterMode enum {LOAD = 2'b00, INC = 2'b01, DEC = 2'b10, HOLD = 2'b11}, shared with mc10136 users.
  - tSeqState enum {IDLE, LOAD, RUN, FIN}.
- One sub-module, seq_watchdog: saturating cycle counter with clear, enable and expired output, parameterized by MAXCYC.

## Test plan
The bench drives a chain of three mc10136 slices (12 bits) from the sequencer.
- Load 5, dir = 0, no stalls: nCryIn low for exactly 5 cycles, chain ends at 0, done in cycle 8, steps = 5, err = 0.
- Load 0, dir = 0: no stepping cycles, done in cycle 3, steps = 0. Load 12'hFFF, dir = 1: same result.
- Load 4, dir = 0, stall high in RUN cycles 2 and 3: done delayed by 2 cycles, steps = 4, chain = 0.
- MAXCYC = 8, load 100, dir = 0: done after 8 RUN cycles with err = 1, steps = 8, chain = 92.
- Load 10, abort at RUN cycle 3: IDLE next cycle, no done, steps = 3, chain holds 7. A start in the same cycle as abort is ignored.
- Reset asserted during RUN: outputs return to reset values asynchronously, and the chain holds its value from then on.
